// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed active-low seven-segment bus,
// waits for each scanned (digit, pattern) pair to be stable, and recovers the
// displayed hex nibble per digit along with its validity.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic                  pattern_err,
  output logic [2:0]            err_digit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  // Inverse segment map: result is {is_hex, is_blank, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] code);
    logic [5:0] res;
    case (code)
      7'b0000001: res = {2'b10, 4'h0};
      7'b1001111: res = {2'b10, 4'h1};
      7'b0010010: res = {2'b10, 4'h2};
      7'b0000110: res = {2'b10, 4'h3};
      7'b1001100: res = {2'b10, 4'h4};
      7'b0100100: res = {2'b10, 4'h5};
      7'b0100000: res = {2'b10, 4'h6};
      7'b0001111: res = {2'b10, 4'h7};
      7'b0000000: res = {2'b10, 4'h8};
      7'b0000100: res = {2'b10, 4'h9};
      7'b0001000: res = {2'b10, 4'hA};
      7'b1100000: res = {2'b10, 4'hB};
      7'b0110001: res = {2'b10, 4'hC};
      7'b1000010: res = {2'b10, 4'hD};
      7'b0110000: res = {2'b10, 4'hE};
      7'b0111000: res = {2'b10, 4'hF};
      7'b1111111: res = {2'b01, 4'h0};
      default:    res = {2'b00, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0]        seg_meta_r, seg_sync_r;
  logic [DIGITS-1:0] an_meta_r, an_sync_r;
  state_t            state_r, state_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [2:0]        lat_idx_r, lat_idx_s;
  logic [6:0]        lat_seg_r, lat_seg_s;
  logic              commit_s;
  logic [2:0]        act_idx_s;
  logic              act_any_s;
  logic [3:0]        low_cnt_s;
  logic              pair_changed_s;
  logic [5:0]        dec_s;

  // Two-stage synchronizer; reset value is blank with no digit selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_r <= 7'h7F;
      seg_sync_r <= 7'h7F;
      an_meta_r  <= {DIGITS{1'b1}};
      an_sync_r  <= {DIGITS{1'b1}};
    end else begin
      seg_meta_r <= seg_n;
      seg_sync_r <= seg_meta_r;
      an_meta_r  <= an_n;
      an_sync_r  <= an_meta_r;
    end
  end

  // Active digit: valid only when exactly one enable is low.
  always_comb begin
    low_cnt_s = 4'd0;
    act_idx_s = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_sync_r[i]) begin
        low_cnt_s = low_cnt_s + 4'd1;
        act_idx_s = 3'(i);
      end else begin
        low_cnt_s = low_cnt_s;
      end
    end
    act_any_s      = (low_cnt_s == 4'd1);
    pair_changed_s = (act_idx_s != lat_idx_r) || (seg_sync_r != lat_seg_r);
  end

  // FSM state, dwell counter and latched pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      lat_idx_r <= 3'd0;
      lat_seg_r <= 7'h7F;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      lat_idx_r <= lat_idx_s;
      lat_seg_r <= lat_seg_s;
    end
  end

  // Next-state logic: track a pair until it has dwelt long enough, then commit once.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    lat_idx_s = lat_idx_r;
    lat_seg_s = lat_seg_r;
    commit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (act_any_s) begin
          lat_idx_s = act_idx_s;
          lat_seg_s = seg_sync_r;
          cnt_s     = 8'd1;
          state_s   = TRACK;
        end else begin
          state_s = IDLE;
        end
      end
      TRACK: begin
        if (!act_any_s) begin
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else if (pair_changed_s) begin
          lat_idx_s = act_idx_s;
          lat_seg_s = seg_sync_r;
          cnt_s     = 8'd1;
        end else if (cnt_r >= STABLE_LIMIT) begin
          commit_s = 1'b1;
          state_s  = DONE;
        end else if (cnt_r != 8'hFF) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        if (!act_any_s) begin
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else if (pair_changed_s) begin
          lat_idx_s = act_idx_s;
          lat_seg_s = seg_sync_r;
          cnt_s     = 8'd1;
          state_s   = TRACK;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        cnt_s   = 8'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Decode of the pair being committed.
  always_comb begin
    dec_s = decode_seg(lat_seg_r);
  end

  // Registered commit actions: hex updates value, blank clears validity, other codes flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      pattern_err <= 1'b0;
      err_digit   <= 3'd0;
    end else begin
      update      <= commit_s & dec_s[5];
      pattern_err <= commit_s & ~dec_s[5] & ~dec_s[4];
      if (commit_s && !dec_s[5] && !dec_s[4]) begin
        err_digit <= lat_idx_r;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (commit_s && (lat_idx_r == 3'(i))) begin
          if (dec_s[5]) begin
            value[4*i +: 4] <= dec_s[3:0];
            digit_valid[i]  <= 1'b1;
          end else if (dec_s[4]) begin
            digit_valid[i]  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers hex digits from a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) by performing the inverse of the team's hex-to-segment mapping. It sits on the observation side of the display path: it snoops the scanned digit/segment signals, filters them for stability, and presents the displayed value as packed nibbles with per-digit validity. It is used for self-check and for readback of what the panel actually shows.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is committed (2..255).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active-low (0 = lit); bit 6 = a … bit 0 = g.
- an_n  in  DIGITS  digit enables, active-low; bit i selects digit i.
- value  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid  out  DIGITS  bit i set when digit i last committed a valid hex pattern.
- update  out  1  one-cycle pulse on every valid-hex commit.
- pattern_err  out  1  one-cycle pulse when a stable pattern is neither hex nor blank.
- err_digit  out  3  index of the digit that raised the most recent pattern_err; holds between errors.

## Operation
- Input sync: seg_n and an_n pass through two flop stages. Both stages reset to all-ones, which is blank and no digit selected.
- Active digit: exactly one synchronized an_n bit low gives an index. Zero or more than one low bits mean "none".
- Pattern map (seg_n, bit6..bit0 → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7.
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F.
  - 1111111 = blank.
  - Every other code is invalid.
- FSM states IDLE, TRACK, DONE, with a saturating dwell counter and a latched (index, seg) pair.
  - IDLE: when the active digit is none, stay. Otherwise latch the pair, set the counter to 1, and go to TRACK.
  - TRACK: if the pair changes, relatch, set the counter to 1, and stay in TRACK. If the active digit becomes none, go to IDLE. If the counter reaches STABLE_CYCLES, commit and go to DONE. Otherwise increment the counter.
  - DONE: stay while the pair is unchanged, with no further commits. A changed pair relatches and goes to TRACK with the counter at 1. None goes to IDLE.
- Commit actions, all registered:
  - Hex: value[i] takes the nibble, digit_valid[i] is set, and update pulses, even if the nibble is unchanged.
  - Blank: digit_valid[i] is cleared, value[i] holds, and there is no pulse.
  - Invalid: pattern_err pulses, err_digit takes i, and value and digit_valid hold.
- Digits never committed keep their reset state.

## Timing
- Reset values: value=0, digit_valid=0, update=0, pattern_err=0, err_digit=0, FSM=IDLE, counter=0.
- Latency: a pair first sampled at edge E0 and held through edge E0+STABLE_CYCLES+1 commits at edge E0+STABLE_CYCLES+1.
  - Outputs are visible from that edge.
  - Example: STABLE_CYCLES=4 commits at E0+5.
- Minimum dwell per scan slot is STABLE_CYCLES+2 clocks. Shorter slots never commit.
- update and pattern_err are exclusive and each lasts exactly one cycle.
- Scan wrap-around: each re-selection of a digit (leaving DONE and returning) recommits and pulses update again.
- Reset mid-dwell: the partial count is discarded and no commit occurs. After release, the sync stages take 2 edges to refill.
- Counter width is 8 bits and saturates. No wrap occurs with STABLE_CYCLES ≤ 255.

## Test plan
- Reset then idle: an_n=1111, seg_n=1111111 for 20 cycles → all outputs 0, no pulses.
- Digit 2 shows 0001000 (A) for 8 cycles → value=16'h0A00, digit_valid=0100, a single update pulse at E0+5.
- Full scan: digits 0..3 show 3,7,C,F for 10 cycles each, then wrap → value=16'hFC73, digit_valid=1111, 4 updates per pass.
- Glitch: digit 1 shows 1 for 3 cycles, then 5 for 8 cycles → only 5 commits, value[7:4]=5, exactly one update.
- Invalid/blank: digit 3 shows 1111110 → pattern_err pulse, err_digit=3, outputs hold. Digit 3 shows 1111111 → digit_valid[3]=0, value[15:12] unchanged.
- Double-select an_n=1100 for 10 cycles → no commit. Assert rst_n at cycle 3 of a valid dwell → no update, outputs at reset values.
